// File: rtl/ptw_axi_arbiter_pkg.sv
// Shared page-walk pipeline constants: privilege modes, AXI encodings and
// the walker arbiter state encoding.
package ptw_axi_arbiter_pkg;

  localparam logic [1:0] PRIV_U = 2'b00;
  localparam logic [1:0] PRIV_S = 2'b01;
  localparam logic [1:0] PRIV_M = 2'b11;

  localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;
  localparam logic [2:0] AXI_SIZE_8B     = 3'd3;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_RESP = 2'd3
  } ptw_state_e;

  // Requester slots; index into the per-requester packed arrays.
  localparam int NUM_REQ = 2;
  localparam int REQ_I   = 0;
  localparam int REQ_D   = 1;

endpackage

// File: rtl/ptw_axi_arbiter_req_latch.sv
// Per-requester pending latch: holds one walk address until granted and
// flags any re-request made while the previous one is still outstanding.
module ptw_req_latch
  import ptw_axi_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = 64
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  req_pulse,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic                  in_flight,
  input  logic                  grant,
  output logic                  req,
  output logic [ADDR_WIDTH-1:0] req_addr_eff,
  output logic                  overflow
);

  logic                  pending;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  accept;

  assign accept       = req_pulse && !pending && !in_flight;
  assign overflow     = req_pulse && (pending || in_flight);
  // A fresh pulse can be granted on its own edge, bypassing the latch.
  assign req          = pending || accept;
  assign req_addr_eff = pending ? addr_q : req_addr;

  always_ff @(posedge CLK) begin
    if (RST) begin
      pending <= 1'b0;
      addr_q  <= '0;
    end else if (grant) begin
      pending <= 1'b0;
    end else if (accept) begin
      pending <= 1'b1;
      addr_q  <= req_addr;
    end
  end

endmodule

// File: rtl/ptw_axi_arbiter.sv
// ITLB/DTLB page-table-walk arbiter onto a single-outstanding AXI4 read port.
module ptw_axi_arbiter
  import ptw_axi_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  I_ADDR_VALID,
  input  logic [ADDR_WIDTH-1:0] I_ADDR,
  output logic                  I_DATA_VALID,
  input  logic                  D_ADDR_VALID,
  input  logic [ADDR_WIDTH-1:0] D_ADDR,
  output logic                  D_DATA_VALID,
  output logic [DATA_WIDTH-1:0] PTE_DATA,
  output logic                  PTE_ACCESS_FAULT,
  output logic                  PROTO_ERR,
  output logic [ADDR_WIDTH-1:0] ARADDR,
  output logic                  ARVALID,
  input  logic                  ARREADY,
  output logic [7:0]            ARLEN,
  output logic [2:0]            ARSIZE,
  output logic [1:0]            ARBURST,
  input  logic [DATA_WIDTH-1:0] RDATA,
  input  logic [1:0]            RRESP,
  input  logic                  RLAST,
  input  logic                  RVALID,
  output logic                  RREADY
);

  ptw_state_e state, state_nxt;

  logic [NUM_REQ-1:0]                 pulse, req, grant, in_flight, overflow;
  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0] addr_in, addr_eff;

  logic                  owner_d;    // 1: DTLB owns the current transaction
  logic                  last_gnt_i; // 1: ITLB was granted most recently
  logic                  arb_en, any_req, win_d, busy, resp_err;
  logic [ADDR_WIDTH-1:0] araddr_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [1:0]            rresp_q;
  logic                  proto_err_q;

  assign pulse   = {D_ADDR_VALID, I_ADDR_VALID};
  assign addr_in = {D_ADDR, I_ADDR};

  genvar g;
  for (g = 0; g < NUM_REQ; g++) begin : g_req
    ptw_req_latch #(.ADDR_WIDTH(ADDR_WIDTH)) u_latch (
      .CLK          (CLK),
      .RST          (RST),
      .req_pulse    (pulse[g]),
      .req_addr     (addr_in[g]),
      .in_flight    (in_flight[g]),
      .grant        (grant[g]),
      .req          (req[g]),
      .req_addr_eff (addr_eff[g]),
      .overflow     (overflow[g])
    );
  end

  // Arbitration happens in IDLE and on the last cycle of RESP for back-to-back issue.
  assign busy      = (state != ST_IDLE);
  assign in_flight = busy ? (owner_d ? 2'b10 : 2'b01) : 2'b00;
  assign arb_en    = (state == ST_IDLE) || (state == ST_RESP);
  assign any_req   = |req;
  assign win_d     = req[REQ_D] && (!req[REQ_I] || last_gnt_i);
  assign grant[REQ_D] = arb_en && win_d;
  assign grant[REQ_I] = arb_en && req[REQ_I] && !win_d;

  always_ff @(posedge CLK) begin
    if (RST) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (any_req) state_nxt = ST_ADDR;
      ST_ADDR: if (ARREADY) state_nxt = ST_DATA;
      ST_DATA: if (RVALID && RLAST) state_nxt = ST_RESP;
      ST_RESP: state_nxt = any_req ? ST_ADDR : ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      owner_d     <= 1'b0;
      last_gnt_i  <= 1'b1;
      araddr_q    <= '0;
      rdata_q     <= '0;
      rresp_q     <= AXI_RESP_OKAY;
      proto_err_q <= 1'b0;
    end else begin
      if (arb_en && any_req) begin
        owner_d    <= win_d;
        last_gnt_i <= !win_d;
        araddr_q   <= win_d ? addr_eff[REQ_D] : addr_eff[REQ_I];
      end
      if (state == ST_DATA && RVALID && RLAST) begin
        rdata_q <= RDATA;
        rresp_q <= RRESP;
      end
      proto_err_q <= proto_err_q || (|overflow);
    end
  end

  assign resp_err         = (rresp_q != AXI_RESP_OKAY);
  assign ARVALID          = (state == ST_ADDR);
  assign ARADDR           = araddr_q;
  assign ARLEN            = 8'd0;
  assign ARSIZE           = AXI_SIZE_8B;
  assign ARBURST          = AXI_BURST_INCR;
  assign RREADY           = (state == ST_DATA);
  assign I_DATA_VALID     = (state == ST_RESP) && !owner_d;
  assign D_DATA_VALID     = (state == ST_RESP) && owner_d;
  assign PTE_ACCESS_FAULT = (state == ST_RESP) && resp_err;
  assign PTE_DATA         = ((state == ST_RESP) && !resp_err) ? rdata_q : '0;
  assign PROTO_ERR        = proto_err_q;

endmodule
